// File: rtl/seq_detect_fsm_if.sv
// Serial stream bundle for seq_detect_fsm.
//   x_in, en, clr, overlap : sampled serial bit, bit-valid, sync history clear, overlap select
//   y_out                  : Mealy match flag (same cycle as the final pattern bit)
//   match_cnt              : saturating match count (all zeros when the counter is not built)
// master modport = stream source / match consumer, slave modport = detector.
interface seq_detect_fsm_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             x_in;
  logic             en;
  logic             clr;
  logic             overlap;
  logic             y_out;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output x_in,
    output en,
    output clr,
    output overlap,
    input  y_out,
    input  match_cnt
  );

  modport slave (
    input  x_in,
    input  en,
    input  clr,
    input  overlap,
    output y_out,
    output match_cnt
  );

endinterface

// File: rtl/seq_detect_fsm.sv
// Parametrised serial pattern detector with a Mealy match flag.
//
// Parameters:
//   N       : pattern length, 2..16
//   PATTERN : N-bit pattern, PATTERN[N-1] arrives first, PATTERN[0] last
//   CNT_W   : match counter width, 1..16
// Ports:
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   bus     : seq_detect_fsm_if slave (x_in/en/clr/overlap in, y_out/match_cnt out)
// Build option:
//   SEQ_DETECT_MATCH_COUNT_EN : when defined, a saturating match counter drives match_cnt;
//                               otherwise match_cnt is tied to zero and no counter is built.
//
// Progress is tracked as StFill (fewer than N-1 bits accepted) and StPrimed (history window
// full); fill_q counts accepted bits and reaches N-1 exactly when the FSM enters StPrimed.
module seq_detect_fsm #(
  parameter int unsigned    N       = 3,
  parameter logic [N-1:0]   PATTERN = 3'b101,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  seq_detect_fsm_if.slave  bus
);

  localparam int unsigned FillW = $clog2(N);

  typedef enum logic [0:0] {
    StFill,
    StPrimed
  } state_e;

  state_e           state_q, state_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [N-2:0]     hist_q, hist_d;
  logic [N-1:0]     window;
  logic             match;

  // Newest bit appended below the history; compared against the whole pattern.
  assign window = {hist_q, bus.x_in};

  // Reset forces StFill asynchronously, so the flag is low for as long as reset is held.
  assign match     = bus.en & ~bus.clr & (state_q == StPrimed) & (window == PATTERN);
  assign bus.y_out = match;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFill;
      fill_q  <= '0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    if (bus.clr) begin
      state_d = StFill;
      fill_d  = '0;
      hist_d  = '0;
    end else if (bus.en) begin
      if (match && !bus.overlap) begin
        // Non-overlapping: the matching bit is not reused for the next detection.
        state_d = StFill;
        fill_d  = '0;
        hist_d  = '0;
      end else begin
        hist_d = window[N-2:0];
        unique case (state_q)
          StFill: begin
            fill_d = fill_q + 1'b1;
            if (fill_q == FillW'(N - 2)) begin
              state_d = StPrimed;
            end
          end
          StPrimed: begin
            // Window stays full; fill_q holds at N-1.
          end
          default: begin
            state_d = StFill;
            fill_d  = '0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.match_cnt = cnt_q;
`else
  assign bus.match_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: three instances share one serial stream
//   d3 : N=3, PATTERN=101, CNT_W=8
//   ds : N=3, PATTERN=101, CNT_W=2 (counter saturation)
//   d8 : N=8, PATTERN=A5
// Inputs change just after the falling edge; y_out is sampled 1 time unit later
// (combinational for the bit about to be accepted), counters reflect all earlier edges.
module tb_seq_detect_fsm;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk;
  logic reset;
  logic x, en, clr, overlap;

  int n_checks = 0;
  int n_errors = 0;

  seq_detect_fsm_if #(.CNT_W(8)) if3 ();
  seq_detect_fsm_if #(.CNT_W(2)) ifs ();
  seq_detect_fsm_if #(.CNT_W(8)) if8 ();

  assign if3.x_in = x;  assign if3.en = en;  assign if3.clr = clr;  assign if3.overlap = overlap;
  assign ifs.x_in = x;  assign ifs.en = en;  assign ifs.clr = clr;  assign ifs.overlap = overlap;
  assign if8.x_in = x;  assign if8.en = en;  assign if8.clr = clr;  assign if8.overlap = overlap;

  seq_detect_fsm #(.N(3), .PATTERN(3'b101), .CNT_W(8)) d3 (.clk(clk), .reset(reset), .bus(if3));
  seq_detect_fsm #(.N(3), .PATTERN(3'b101), .CNT_W(2)) ds (.clk(clk), .reset(reset), .bus(ifs));
  seq_detect_fsm #(.N(8), .PATTERN(8'hA5), .CNT_W(8)) d8 (.clk(clk), .reset(reset), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int v);
    return CntEn ? 32'(v) : 32'd0;
  endfunction

  task automatic chk_cnt(input string tag, input int e3, input int es);
    check({tag, "_cnt3"}, 32'(if3.match_cnt), cnt_exp(e3));
    check({tag, "_cnts"}, 32'(ifs.match_cnt), cnt_exp(es));
  endtask

  // Present one input cycle and check the N=3 flags for it.
  task automatic step(input logic xb, input logic eb, input logic cb, input logic ey,
                      input string tag);
    @(negedge clk);
    x = xb; en = eb; clr = cb;
    #1;
    check({tag, "_y3"}, 32'(if3.y_out), 32'(ey));
    check({tag, "_ys"}, 32'(ifs.y_out), 32'(ey));
  endtask

  logic [11:0] wstream;

  initial begin
    reset = 1'b0; x = 1'b0; en = 1'b0; clr = 1'b0; overlap = 1'b1;
    wstream = 12'hAA5;

    // Reset held: flag low even with en=1, x=1
    @(negedge clk);
    @(negedge clk);
    x = 1'b1; en = 1'b1;
    #1;
    check("rst_y3", 32'(if3.y_out), 32'd0);
    check("rst_y8", 32'(if8.y_out), 32'd0);
    @(posedge clk);
    #1;
    check("rst_y3b", 32'(if3.y_out), 32'd0);
    chk_cnt("rst", 0, 0);
    @(negedge clk);
    reset = 1'b1; en = 1'b0; x = 1'b0;

    // Overlap: 1,0,1,0,1 -> matches on bits 3 and 5
    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, "ov1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "ov2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "ov3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "ov4");
    chk_cnt("ov4", 1, 1);
    step(1'b1, 1'b1, 1'b0, 1'b1, "ov5");
    step(1'b0, 1'b0, 1'b0, 1'b0, "ov_idle");
    chk_cnt("ov_end", 2, 2);

    // Non-overlap: 1,0,1,0,1 -> match on bit 3 only
    overlap = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, "no_clr");
    chk_cnt("no_clr", 2, 2);
    step(1'b1, 1'b1, 1'b0, 1'b0, "no1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "no2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "no3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "no4");
    chk_cnt("no4", 3, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, "no5");
    // Restart after a match, then 0,1,0,1 -> match on final bit
    step(1'b0, 1'b1, 1'b1, 1'b0, "no_clr2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "nb1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "nb2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "nb3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "nc1");
    chk_cnt("nc1", 4, 3);
    step(1'b1, 1'b1, 1'b0, 1'b0, "nc2");
    step(1'b0, 1'b1, 1'b0, 1'b0, "nc3");
    step(1'b1, 1'b1, 1'b0, 1'b1, "nc4");
    step(1'b0, 1'b0, 1'b0, 1'b0, "nc_idle");
    chk_cnt("nc_end", 5, 3);

    // Enable gaps
    overlap = 1'b1;
    step(1'b0, 1'b1, 1'b1, 1'b0, "en_clr");
    step(1'b1, 1'b1, 1'b0, 1'b0, "en1");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "en_gap");
    step(1'b0, 1'b1, 1'b0, 1'b0, "en2");
    step(1'b1, 1'b1, 1'b0, 1'b1, "en3");
    step(1'b0, 1'b0, 1'b0, 1'b0, "en_idle");
    chk_cnt("en_end", 6, 3);

    // clr wins over a would-be match
    step(1'b0, 1'b1, 1'b1, 1'b0, "cl_clr");
    step(1'b1, 1'b1, 1'b0, 1'b0, "cl1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "cl2");
    step(1'b1, 1'b1, 1'b1, 1'b0, "cl_win");
    step(1'b1, 1'b1, 1'b0, 1'b0, "cl3");
    chk_cnt("cl_win", 6, 3);
    step(1'b0, 1'b1, 1'b0, 1'b0, "cl4");
    step(1'b1, 1'b1, 1'b0, 1'b1, "cl5");
    step(1'b0, 1'b0, 1'b0, 1'b0, "cl_idle");
    chk_cnt("cl_end", 7, 3);

    // Reset mid-pattern, low for one rising edge
    step(1'b1, 1'b1, 1'b0, 1'b0, "rs1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "rs2");
    @(negedge clk);
    reset = 1'b0; x = 1'b1; en = 1'b1; clr = 1'b0;
    #1;
    check("rs_low_y3", 32'(if3.y_out), 32'd0);
    check("rs_low_ys", 32'(ifs.y_out), 32'd0);
    chk_cnt("rs_low", 0, 0);
    @(negedge clk);
    reset = 1'b1; en = 1'b0;
    #1;
    chk_cnt("rs_rel", 0, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "rs3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "rs4");
    step(1'b1, 1'b1, 1'b0, 1'b1, "rs5");
    step(1'b0, 1'b0, 1'b0, 1'b0, "rs_idle");
    chk_cnt("rs_end", 1, 1);

    // N=8: 0xA then 0xA5 MSB-first -> single pulse on bit 12
    step(1'b0, 1'b1, 1'b1, 1'b0, "w_clr");
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      x = wstream[11-i]; en = 1'b1; clr = 1'b0;
      #1;
      check($sformatf("w8_bit%0d", i + 1), 32'(if8.y_out), (i == 11) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
